// File: rtl/bus_mux_n_pkg.sv
// +----------------------------------------------------------------------+
// | bus_mux_pkg : shared types and constants for the bus_mux_n block     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bus_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_DECODE  = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_e;

    localparam logic [31:0] C_ERR_DATA_DEFAULT = 32'hdeadbeef;

endpackage : bus_mux_pkg

`default_nettype wire

// File: rtl/bus_mux_n_if.sv
// +----------------------------------------------------------------------+
// | bus_mux_n_if : CPU-side and slave-side bus signals of bus_mux_n      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface bus_mux_n_if #(
    parameter int N_SLAVES = 3
);
    logic [31:0]            i_la_addr;
    logic [31:0]            i_addr;
    logic                   i_valid;
    logic                   o_ready;
    logic [31:0]            o_rdata;
    logic [N_SLAVES-1:0]    o_slave_valid;
    logic [N_SLAVES-1:0]    i_slave_ready;
    logic [N_SLAVES*32-1:0] i_slave_rdata;

    // The mux is the slave of this bundle.
    modport slave (
        input  i_la_addr,
        input  i_addr,
        input  i_valid,
        input  i_slave_ready,
        input  i_slave_rdata,
        output o_ready,
        output o_rdata,
        output o_slave_valid
    );

    // The CPU plus the downstream slaves together form the master side.
    modport master (
        output i_la_addr,
        output i_addr,
        output i_valid,
        output i_slave_ready,
        output i_slave_rdata,
        input  o_ready,
        input  o_rdata,
        input  o_slave_valid
    );

endinterface : bus_mux_n_if

`default_nettype wire

// File: rtl/bus_mux_n_decoder.sv
// +----------------------------------------------------------------------+
// | bus_addr_decoder : combinational priority address decoder            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_addr_decoder #(
    parameter int                     N_SLAVES   = 3,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h01000000, 32'h00010000, 32'h00000000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'hfffff000, 32'hffff0000, 32'hffff0000}
) (
    input  wire logic [31:0]         i_addr,
    output logic      [N_SLAVES-1:0] o_sel,
    output logic                     o_hit
);

    logic [N_SLAVES-1:0] w_match;

    for (genvar k = 0; k < N_SLAVES; k++) begin : g_match
        assign w_match[k] = ((i_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]);
    end

    // Isolating the lowest set bit gives the lowest index priority on overlaps.
    assign o_sel = w_match & (~w_match + 1'b1);
    assign o_hit = |w_match;

endmodule : bus_addr_decoder

`default_nettype wire

// File: rtl/bus_mux_n.sv
// +----------------------------------------------------------------------+
// | bus_mux_n : PicoRV32 bus to N slaves, decode-miss and watchdog errors|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_mux_n
    import bus_mux_pkg::*;
#(
    parameter int                     N_SLAVES   = 3,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h01000000, 32'h00010000, 32'h00000000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'hfffff000, 32'hffff0000, 32'hffff0000},
    parameter int unsigned            TIMEOUT    = 255,
    parameter logic [31:0]            ERR_DATA   = C_ERR_DATA_DEFAULT
) (
    input  wire logic        clock,
    input  wire logic        resetn,
    bus_mux_n_if.slave       bus,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    output logic [31:0]      o_err_addr,
    output logic [15:0]      o_err_count
);

    localparam int              CNT_W         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit              C_WDOG_EN     = (TIMEOUT != 0);

    state_e                 state_q, state_d;
    logic [N_SLAVES-1:0]    sel_q, sel_d;
    logic                   hit_q, hit_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    err_code_e              err_code_q, err_code_d;
    logic [31:0]            err_addr_q, err_addr_d;
    logic [15:0]            err_count_q, err_count_d;

    logic [N_SLAVES-1:0]    w_dec_sel;
    logic                   w_dec_hit;
    logic                   w_routed;
    logic                   w_sel_ready;
    logic                   w_ready;
    logic                   w_timeout;
    logic                   w_enter_err;
    logic [31:0]            w_sel_rdata;
    logic [31:0]            w_rdata_or [N_SLAVES+1];

    bus_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .i_addr (bus.i_la_addr),
        .o_sel  (w_dec_sel),
        .o_hit  (w_dec_hit)
    );

    // AND-OR read-data mux driven by the registered one-hot select.
    assign w_rdata_or[0] = '0;
    for (genvar k = 0; k < N_SLAVES; k++) begin : g_rdata
        assign w_rdata_or[k+1] = w_rdata_or[k] |
                                 (sel_q[k] ? bus.i_slave_rdata[32*k +: 32] : 32'h0);
    end
    assign w_sel_rdata = w_rdata_or[N_SLAVES];

    assign w_routed    = bus.i_valid & hit_q & (state_q != ST_ERROR);
    assign w_sel_ready = |(sel_q & bus.i_slave_ready);
    assign w_ready     = (state_q == ST_ERROR) | (w_routed & w_sel_ready);
    assign w_timeout   = C_WDOG_EN && (state_q == ST_ACTIVE) && w_routed &&
                         !w_sel_ready && (cnt_q == C_TIMEOUT_CNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    if (!hit_q) begin
                        state_d = ST_ERROR;
                    end else if (!w_sel_ready) begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                // A ready in the timeout cycle still completes normally.
                if (!bus.i_valid || w_sel_ready) begin
                    state_d = ST_IDLE;
                end else if (w_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign w_enter_err = (state_d == ST_ERROR) && (state_q != ST_ERROR);

    always_comb begin
        sel_d       = sel_q;
        hit_d       = hit_q;
        cnt_d       = '0;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        // Decode is frozen while a transaction waits for its slave.
        if (!bus.i_valid || w_ready) begin
            sel_d = w_dec_sel;
            hit_d = w_dec_hit;
        end

        if (C_WDOG_EN && w_routed && !w_sel_ready && !w_timeout) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (w_enter_err) begin
            err_code_d = (state_q == ST_IDLE) ? ERR_DECODE : ERR_TIMEOUT;
            err_addr_d = bus.i_addr;
            if (err_count_q != 16'hffff) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            hit_q       <= 1'b0;
            cnt_q       <= '0;
            err_code_q  <= ERR_NONE;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            hit_q       <= hit_d;
            cnt_q       <= cnt_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.o_ready       = w_ready;
    assign bus.o_slave_valid = w_routed ? sel_q : '0;
    assign bus.o_rdata       = (state_q == ST_ERROR) ? ERR_DATA :
                               (w_routed ? w_sel_rdata : 32'h0);

    assign o_err       = (state_q == ST_ERROR);
    assign o_err_code  = err_code_q;
    assign o_err_addr  = err_addr_q;
    assign o_err_count = err_count_q;

endmodule : bus_mux_n

`default_nettype wire

// File: tb/tb_bus_mux_n.sv
// +----------------------------------------------------------------------+
// | tb_bus_mux_n : directed self-checking bench for bus_mux_n            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bus_mux_n;

    localparam int              NS   = 3;
    localparam int              TO   = 8;
    localparam logic [NS*32-1:0] BASE = {32'h01000000, 32'h00010000, 32'h00000000};
    localparam logic [NS*32-1:0] MASK = {32'hfffff000, 32'hffff0000, 32'hffff0000};
    localparam logic [31:0]     EDAT = 32'hdeadbeef;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic [31:0] o_err_addr;
    logic [15:0] o_err_count;

    always #5 clock = ~clock;

    bus_mux_n_if #(.N_SLAVES(NS)) bus ();

    bus_mux_n #(
        .N_SLAVES   (NS),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (TO),
        .ERR_DATA   (EDAT)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_err_addr  (o_err_addr),
        .o_err_count (o_err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic          chk_en   = 1'b0;
    logic          exp_ready;
    logic [31:0]   exp_rdata;
    logic [NS-1:0] exp_sv;
    logic          exp_err;
    logic [1:0]    m_code   = 2'b00;
    logic [31:0]   m_addr   = 32'h0;
    logic [15:0]   m_count  = 16'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Address map lookup: first matching slave in index order, -1 on a miss.
    function automatic int model_target(input logic [31:0] a);
        for (int k = 0; k < NS; k++) begin
            if ((a & 32'(MASK >> (32 * k))) == 32'(BASE >> (32 * k))) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] slave_dat(input int k, input logic [31:0] a);
        return 32'hA0000000 + (32'(k) << 24) + a;
    endfunction

    task automatic set_idle_exp();
        exp_ready = 1'b0;
        exp_rdata = 32'h0;
        exp_sv    = '0;
        exp_err   = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en && resetn) begin
            check("o_ready",       32'(bus.o_ready),       32'(exp_ready));
            check("o_rdata",       bus.o_rdata,            exp_rdata);
            check("o_slave_valid", 32'(bus.o_slave_valid), 32'(exp_sv));
            check("o_err",         32'(o_err),             32'(exp_err));
            check("o_err_code",    32'(o_err_code),        32'(m_code));
            check("o_err_addr",    o_err_addr,             m_addr);
            check("o_err_count",   32'(o_err_count),       32'(m_count));
        end
    end

    // rdy_cyc: valid cycle (1-based) in which the target raises ready, 0 = never.
    // abort_n: stop after checking that cycle without completing, 0 = run to end.
    task automatic do_txn(input logic [31:0] addr, input int rdy_cyc, input int abort_n);
        int              tgt;
        int              end_n;
        bit              hit_done;
        logic [NS*32-1:0] pk;
        logic [NS-1:0]   rv;
        tgt = model_target(addr);
        pk  = '0;
        for (int k = NS - 1; k >= 0; k--) pk = (pk << 32) | (NS*32)'(slave_dat(k, addr));
        bus.i_slave_rdata = pk;

        bus.i_valid   = 1'b0;
        bus.i_la_addr = addr;
        set_idle_exp();
        @(posedge clock);
        #1;

        hit_done = (tgt >= 0) && (rdy_cyc >= 1) && (rdy_cyc <= TO + 1);
        if (tgt < 0)       end_n = 2;
        else if (hit_done) end_n = rdy_cyc;
        else               end_n = TO + 2;

        bus.i_valid = 1'b1;
        bus.i_addr  = addr;
        for (int n = 1; n <= end_n; n++) begin
            rv = '0;
            for (int k = NS - 1; k >= 0; k--) begin
                rv = (rv << 1) | NS'((k == tgt) ? (rdy_cyc > 0 && n >= rdy_cyc) : 1'b1);
            end
            bus.i_slave_ready = rv;

            if (tgt >= 0 && (n < end_n || hit_done)) begin
                exp_sv    = NS'(1) << tgt;
                exp_rdata = slave_dat(tgt, addr);
                exp_ready = hit_done && (n == end_n);
                exp_err   = 1'b0;
            end else if (n == end_n) begin
                exp_sv    = '0;
                exp_rdata = EDAT;
                exp_ready = 1'b1;
                exp_err   = 1'b1;
                m_code    = (tgt < 0) ? 2'b01 : 2'b10;
                m_addr    = addr;
                if (m_count != 16'hffff) m_count = m_count + 16'd1;
            end else begin
                set_idle_exp();
            end

            if (n == abort_n) begin
                @(negedge clock);
                #1;
                return;
            end
            @(posedge clock);
            #1;
        end
        bus.i_valid = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        bus.i_la_addr     = '0;
        bus.i_addr        = '0;
        bus.i_valid       = 1'b0;
        bus.i_slave_ready = '0;
        bus.i_slave_rdata = '0;
        set_idle_exp();

        #1;
        check("rst_ready",     32'(bus.o_ready),       32'h0);
        check("rst_rdata",     bus.o_rdata,            32'h0);
        check("rst_sv",        32'(bus.o_slave_valid), 32'h0);
        check("rst_err",       32'(o_err),             32'h0);
        check("rst_err_count", 32'(o_err_count),       32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;

        do_txn(32'h00000010, 2, 0);
        do_txn(32'h01000004, 1, 0);
        check("lit_count_after_hits", 32'(o_err_count), 32'h0);

        do_txn(32'h02000000, 0, 0);
        check("lit_miss_code",  32'(o_err_code), 32'h1);
        check("lit_miss_addr",  o_err_addr,      32'h02000000);
        check("lit_miss_count", 32'(o_err_count), 32'h1);

        do_txn(32'h00010000, 0, 0);
        check("lit_to_code",  32'(o_err_code), 32'h2);
        check("lit_to_addr",  o_err_addr,      32'h00010000);
        check("lit_to_count", 32'(o_err_count), 32'h2);

        do_txn(32'h00010004, 9, 0);
        check("lit_ready9_count", 32'(o_err_count), 32'h2);
        do_txn(32'h0001fffc, 10, 0);
        check("lit_ready10_count", 32'(o_err_count), 32'h3);

        do_txn(32'h01000ffc, 3, 0);
        do_txn(32'h01001000, 0, 0);
        check("lit_edge_miss_count", 32'(o_err_count), 32'h4);
        do_txn(32'h0000fff0, 1, 0);

        do_txn(32'h00000020, 0, 3);
        chk_en      = 1'b0;
        resetn      = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        check("arst_ready",     32'(bus.o_ready),       32'h0);
        check("arst_rdata",     bus.o_rdata,            32'h0);
        check("arst_sv",        32'(bus.o_slave_valid), 32'h0);
        check("arst_err",       32'(o_err),             32'h0);
        check("arst_err_code",  32'(o_err_code),        32'h0);
        check("arst_err_addr",  o_err_addr,             32'h0);
        check("arst_err_count", 32'(o_err_count),       32'h0);
        m_code  = 2'b00;
        m_addr  = 32'h0;
        m_count = 16'h0;
        set_idle_exp();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;

        do_txn(32'h00000030, 3, 0);
        check("lit_post_reset_count", 32'(o_err_count), 32'h0);
        @(posedge clock);
        #1;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bus_mux_n

`default_nettype wire
